// File: rtl/riscv_imm_pkg.sv
// Shared immediate-format definitions for the extender and the field packer.
// Format selects, per-format instr[31:7] masks and the packer result bundle.
package riscv_imm_pkg;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;
  localparam logic [2:0] FMT_R = 3'b111;

  localparam int FIELD_W = 25;

  localparam logic [FIELD_W-1:0] MASK_I = 25'h1FF_E000;
  localparam logic [FIELD_W-1:0] MASK_S = 25'h1FC_001F;
  localparam logic [FIELD_W-1:0] MASK_B = 25'h1FC_001F;
  localparam logic [FIELD_W-1:0] MASK_U = 25'h1FF_FFE0;
  localparam logic [FIELD_W-1:0] MASK_J = 25'h1FF_FFE0;

  typedef struct packed {
    logic [FIELD_W-1:0] field;
    logic [FIELD_W-1:0] mask;
    logic               err;
  } imm_res_t;

  // True when every bit of the slice carries the same value.
  function automatic logic all_eq(input logic [20:0] v, input int n);
    logic ones;
    logic zeros;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int k = 0; k < 21; k++) begin
      if (k < n) begin
        ones  = ones & v[k];
        zeros = zeros & ~v[k];
      end
    end
    return ones | zeros;
  endfunction

endpackage

// File: rtl/imm_field_encode.sv
// Combinational immediate -> instr[31:7] field map with optional range check.
// IMM_RANGE_CHECK_EN adds fit checks; otherwise only bad formats flag err.
module imm_field_encode
  import riscv_imm_pkg::*;
(
  input  logic [31:0] imm_i,
  input  logic [2:0]  sel_i,
  output imm_res_t    res_o
);

  logic rng_err;

`ifdef IMM_RANGE_CHECK_EN
  // Flag immediates that do not survive sign-extension by the decoder.
  always_comb begin
    rng_err = 1'b0;
    unique case (1'b1)
      (sel_i == FMT_I),
      (sel_i == FMT_S): rng_err = ~all_eq(imm_i[31:11], 21);
      (sel_i == FMT_B): rng_err = ~all_eq({1'b0, imm_i[31:12]}, 20)
                                  | imm_i[0];
      (sel_i == FMT_J): rng_err = ~all_eq({9'b0, imm_i[31:20]}, 12)
                                  | imm_i[0];
      (sel_i == FMT_U): rng_err = |imm_i[11:0];
      default:          rng_err = 1'b0;
    endcase
  end
`else
  assign rng_err = 1'b0;
`endif

  // Scatter immediate bits into the format's instruction positions.
  always_comb begin
    res_o = '0;
    unique case (1'b1)
      (sel_i == FMT_I): begin
        res_o.field[24:13] = imm_i[11:0];
        res_o.mask         = MASK_I;
      end
      (sel_i == FMT_S): begin
        res_o.field[24:18] = imm_i[11:5];
        res_o.field[4:0]   = imm_i[4:0];
        res_o.mask         = MASK_S;
      end
      (sel_i == FMT_B): begin
        res_o.field[24]    = imm_i[12];
        res_o.field[23:18] = imm_i[10:5];
        res_o.field[4:1]   = imm_i[4:1];
        res_o.field[0]     = imm_i[11];
        res_o.mask         = MASK_B;
      end
      (sel_i == FMT_U): begin
        res_o.field[24:5]  = imm_i[31:12];
        res_o.mask         = MASK_U;
      end
      (sel_i == FMT_J): begin
        res_o.field[24]    = imm_i[20];
        res_o.field[23:14] = imm_i[10:1];
        res_o.field[13]    = imm_i[11];
        res_o.field[12:5]  = imm_i[19:12];
        res_o.mask         = MASK_J;
      end
      default: begin
        res_o.err = 1'b1;
      end
    endcase
    if (rng_err) begin
      res_o.err = 1'b1;
    end
  end

endmodule

// File: rtl/imm_field_packer.sv
// Buffered immediate field packer: encoder, result FIFO and pop statistics.
// Build with IMM_RANGE_CHECK_EN to flag immediates that do not fit.
module imm_field_packer
  import riscv_imm_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_imm,
  input  logic [2:0]       in_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      out_field,
  output logic [24:0]      out_mask,
  output logic             out_err,
  output logic [CNT_W-1:0] packed_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  imm_res_t enc;
  imm_res_t head;
  imm_res_t mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] pk_cnt_q, pk_cnt_d;
  logic [CNT_W-1:0] er_cnt_q, er_cnt_d;

  logic push;
  logic pop;
  logic full;

  imm_field_encode u_enc (
    .imm_i (in_imm),
    .sel_i (in_select),
    .res_o (enc)
  );

  assign full      = (cnt_q == CW'(DEPTH));
  assign in_ready  = ~full;
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_ptr_q];

  assign out_field  = out_valid ? head.field : '0;
  assign out_mask   = out_valid ? head.mask  : '0;
  assign out_err    = out_valid ? head.err   : 1'b0;
  assign packed_cnt = pk_cnt_q;
  assign err_cnt    = er_cnt_q;

  // Next-state for pointers, occupancy and statistics.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    pk_cnt_d = pk_cnt_q;
    er_cnt_d = er_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      pk_cnt_d = pk_cnt_q + CNT_W'(1);
      if (head.err && !(&er_cnt_q)) begin
        er_cnt_d = er_cnt_q + CNT_W'(1);
      end
    end
    unique case (1'b1)
      (push && !pop): cnt_d = cnt_q + CW'(1);
      (pop && !push): cnt_d = cnt_q - CW'(1);
      default:        cnt_d = cnt_q;
    endcase
  end

  // Result storage; contents are only visible while occupancy says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enc;
    end
  end

  // Control state; reset drops any in-flight entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pk_cnt_q <= '0;
      er_cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      pk_cnt_q <= pk_cnt_d;
      er_cnt_q <= er_cnt_d;
    end
  end

endmodule
